pong_game_ctrl: RTL and testbench

Game-state controller for the pong top level. It consumes ball-exit (miss) events and the raw serve buttons and owns the serve/play/point/game-over sequence. It drives the per-player score digits used by the score-digit sprite renderer, and emits the launch and hold controls consumed by the ball-motion logic. It advances its point-delay timer only on a per-frame strobe taken from the vsync falling edge.

---
 rtl/pong_game_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// Pong game-state controller: serve / play / point-hold / game-over sequencing,
// score keeping, and ball launch/hold control for the ball-motion logic.
//
// state | meaning
// SERVE | ball held, waiting for the designated server's button
// PLAY  | ball in motion, waiting for a miss
// POINT | ball held for POINT_FRAMES frames after a score
// OVER  | match won, waiting for any serve press to restart
module pong_game_ctrl #(
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned POINT_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       miss_l,
  input  logic       miss_r,
  input  logic       p1_srv,
  input  logic       p2_srv,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] serve_side,
  output logic       launch,
  output logic       launch_dir,
  output logic       ball_hold,
  output logic       point,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    POINT = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam logic [3:0] WIN_Q   = 4'(WIN_SCORE);
  localparam logic [7:0] CNT_END = 8'(POINT_FRAMES - 1);

  state_t     state_q, state_d;
  logic [3:0] score1_q, score1_d;
  logic [3:0] score2_q, score2_d;
  logic [1:0] serve_side_q, serve_side_d;
  logic       launch_q, launch_d;
  logic       launch_dir_q, launch_dir_d;
  logic       ball_hold_q, ball_hold_d;
  logic       point_q, point_d;
  logic       game_over_q, game_over_d;
  logic [1:0] winner_q, winner_d;
  logic [7:0] cnt_q, cnt_d;
  logic       scorer_q, scorer_d;   // 0 = P1 scored last point, 1 = P2
  logic       p1_srv_q, p2_srv_q, miss_l_q, miss_r_q;

  logic p1_rise, p2_rise, miss_l_rise, miss_r_rise;
  logic scorer_won;

  assign p1_rise     = p1_srv & ~p1_srv_q;
  assign p2_rise     = p2_srv & ~p2_srv_q;
  assign miss_l_rise = miss_l & ~miss_l_q;
  assign miss_r_rise = miss_r & ~miss_r_q;
  assign scorer_won  = scorer_q ? (score2_q == WIN_Q) : (score1_q == WIN_Q);

  // Button history resets high so a button held across reset release must be
  // seen low before it can serve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SERVE;
      score1_q     <= 4'd0;
      score2_q     <= 4'd0;
      serve_side_q <= 2'b01;
      launch_q     <= 1'b0;
      launch_dir_q <= 1'b0;
      ball_hold_q  <= 1'b1;
      point_q      <= 1'b0;
      game_over_q  <= 1'b0;
      winner_q     <= 2'b00;
      cnt_q        <= 8'd0;
      scorer_q     <= 1'b0;
      p1_srv_q     <= 1'b1;
      p2_srv_q     <= 1'b1;
      miss_l_q     <= 1'b0;
      miss_r_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      serve_side_q <= serve_side_d;
      launch_q     <= launch_d;
      launch_dir_q <= launch_dir_d;
      ball_hold_q  <= ball_hold_d;
      point_q      <= point_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
      cnt_q        <= cnt_d;
      scorer_q     <= scorer_d;
      p1_srv_q     <= p1_srv;
      p2_srv_q     <= p2_srv;
      miss_l_q     <= miss_l;
      miss_r_q     <= miss_r;
    end
  end

  always_comb begin
    state_d      = state_q;
    score1_d     = score1_q;
    score2_d     = score2_q;
    serve_side_d = serve_side_q;
    launch_d     = 1'b0;
    launch_dir_d = launch_dir_q;
    ball_hold_d  = ball_hold_q;
    point_d      = 1'b0;
    game_over_d  = game_over_q;
    winner_d     = winner_q;
    cnt_d        = cnt_q;
    scorer_d     = scorer_q;

    case (state_q)
      SERVE: begin
        if (p1_rise && serve_side_q[1]) begin
          state_d      = PLAY;
          launch_d     = 1'b1;
          launch_dir_d = 1'b0;
          serve_side_d = 2'b00;
          ball_hold_d  = 1'b0;
        end else if (p2_rise && serve_side_q[0]) begin
          state_d      = PLAY;
          launch_d     = 1'b1;
          launch_dir_d = 1'b1;
          serve_side_d = 2'b00;
          ball_hold_d  = 1'b0;
        end
      end
      PLAY: begin
        if (miss_l_rise) begin
          state_d     = POINT;
          point_d     = 1'b1;
          ball_hold_d = 1'b1;
          scorer_d    = 1'b1;
          cnt_d       = 8'd0;
          if (score2_q < WIN_Q) score2_d = score2_q + 4'd1;
        end else if (miss_r_rise) begin
          state_d     = POINT;
          point_d     = 1'b1;
          ball_hold_d = 1'b1;
          scorer_d    = 1'b0;
          cnt_d       = 8'd0;
          if (score1_q < WIN_Q) score1_d = score1_q + 4'd1;
        end
      end
      POINT: begin
        if (frame_tick) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == CNT_END) begin
            if (scorer_won) begin
              state_d     = OVER;
              game_over_d = 1'b1;
              winner_d    = scorer_q ? 2'b01 : 2'b10;
            end else begin
              state_d      = SERVE;
              serve_side_d = scorer_q ? 2'b10 : 2'b01;
            end
          end
        end
      end
      OVER: begin
        if (p1_rise || p2_rise) begin
          state_d      = SERVE;
          score1_d     = 4'd0;
          score2_d     = 4'd0;
          winner_d     = 2'b00;
          game_over_d  = 1'b0;
          serve_side_d = scorer_q ? 2'b10 : 2'b01;
        end
      end
      default: state_d = SERVE;
    endcase
  end

  assign score1     = score1_q;
  assign score2     = score2_q;
  assign serve_side = serve_side_q;
  assign launch     = launch_q;
  assign launch_dir = launch_dir_q;
  assign ball_hold  = ball_hold_q;
  assign point      = point_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: two instances (default hold, and a one-frame hold)
// checked every cycle against a behavioural game model, plus scripted scenarios.
module tb_pong_game_ctrl;

  localparam int PH_SERVE = 0;
  localparam int PH_PLAY  = 1;
  localparam int PH_POINT = 2;
  localparam int PH_OVER  = 3;
  localparam int WIN      = 9;

  typedef struct {
    int         phase;
    int         s1, s2;
    logic [1:0] side;
    logic       launch, dir, point, go;
    logic [1:0] win;
    int         left;      // frame ticks still to wait in the point hold
    int         scorer;    // 1 = P1, 2 = P2
    logic       p1p, p2p, mlp, mrp;
  } mdl_t;

  logic clk, rst_n, frame_tick, miss_l, miss_r, p1_srv, p2_srv;
  logic [3:0] a_score1, a_score2, b_score1, b_score2;
  logic [1:0] a_serve_side, a_winner, b_serve_side, b_winner;
  logic a_launch, a_launch_dir, a_ball_hold, a_point, a_game_over;
  logic b_launch, b_launch_dir, b_ball_hold, b_point, b_game_over;

  int   n_vec = 0;
  int   n_miss = 0;
  mdl_t m0, m1;

  pong_game_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .miss_l(miss_l), .miss_r(miss_r),
    .p1_srv(p1_srv), .p2_srv(p2_srv), .score1(a_score1), .score2(a_score2),
    .serve_side(a_serve_side), .launch(a_launch), .launch_dir(a_launch_dir),
    .ball_hold(a_ball_hold), .point(a_point), .game_over(a_game_over), .winner(a_winner)
  );

  pong_game_ctrl #(.WIN_SCORE(9), .POINT_FRAMES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .miss_l(miss_l), .miss_r(miss_r),
    .p1_srv(p1_srv), .p2_srv(p2_srv), .score1(b_score1), .score2(b_score2),
    .serve_side(b_serve_side), .launch(b_launch), .launch_dir(b_launch_dir),
    .ball_hold(b_ball_hold), .point(b_point), .game_over(b_game_over), .winner(b_winner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic mdl_t mreset();
    mdl_t m;
    m.phase = PH_SERVE; m.s1 = 0; m.s2 = 0; m.side = 2'b01;
    m.launch = 1'b0; m.dir = 1'b0; m.point = 1'b0; m.go = 1'b0; m.win = 2'b00;
    m.left = 0; m.scorer = 0;
    // a button held through reset is treated as already pressed
    m.p1p = 1'b1; m.p2p = 1'b1; m.mlp = 1'b0; m.mrp = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input int pf, input logic p1, input logic p2,
                                 input logic ml, input logic mr, input logic ft);
    mdl_t n;
    logic p1r, p2r, mlr, mrr;
    n = m;
    p1r = p1 & ~m.p1p; p2r = p2 & ~m.p2p;
    mlr = ml & ~m.mlp; mrr = mr & ~m.mrp;
    n.p1p = p1; n.p2p = p2; n.mlp = ml; n.mrp = mr;
    n.launch = 1'b0; n.point = 1'b0;
    case (m.phase)
      PH_SERVE: begin
        if (p1r && m.side[1]) begin
          n.phase = PH_PLAY; n.launch = 1'b1; n.dir = 1'b0; n.side = 2'b00;
        end else if (p2r && m.side[0]) begin
          n.phase = PH_PLAY; n.launch = 1'b1; n.dir = 1'b1; n.side = 2'b00;
        end
      end
      PH_PLAY: begin
        if (mlr) begin
          n.s2 = (m.s2 < WIN) ? m.s2 + 1 : m.s2;
          n.point = 1'b1; n.scorer = 2; n.left = pf; n.phase = PH_POINT;
        end else if (mrr) begin
          n.s1 = (m.s1 < WIN) ? m.s1 + 1 : m.s1;
          n.point = 1'b1; n.scorer = 1; n.left = pf; n.phase = PH_POINT;
        end
      end
      PH_POINT: begin
        if (ft) begin
          n.left = m.left - 1;
          if (n.left == 0) begin
            if ((m.scorer == 1 ? m.s1 : m.s2) == WIN) begin
              n.phase = PH_OVER; n.go = 1'b1;
              n.win = (m.scorer == 1) ? 2'b10 : 2'b01;
            end else begin
              n.phase = PH_SERVE;
              n.side = (m.scorer == 1) ? 2'b01 : 2'b10;
            end
          end
        end
      end
      default: begin
        if (p1r || p2r) begin
          n.phase = PH_SERVE; n.s1 = 0; n.s2 = 0; n.win = 2'b00; n.go = 1'b0;
          n.side = (m.scorer == 1) ? 2'b01 : 2'b10;
        end
      end
    endcase
    return n;
  endfunction

  task automatic check_out(input string p, input mdl_t m, input logic [3:0] s1, input logic [3:0] s2,
                           input logic [1:0] sd, input logic la, input logic ld, input logic bh,
                           input logic pt, input logic go, input logic [1:0] wn);
    chk({p, ".score1"},     32'(s1), 32'(m.s1));
    chk({p, ".score2"},     32'(s2), 32'(m.s2));
    chk({p, ".serve_side"}, 32'(sd), 32'(m.side));
    chk({p, ".launch"},     32'(la), 32'(m.launch));
    chk({p, ".ball_hold"},  32'(bh), 32'(m.phase != PH_PLAY));
    chk({p, ".point"},      32'(pt), 32'(m.point));
    chk({p, ".game_over"},  32'(go), 32'(m.go));
    chk({p, ".winner"},     32'(wn), 32'(m.win));
    if (m.launch) chk({p, ".launch_dir"}, 32'(ld), 32'(m.dir));
  endtask

  task automatic check_both();
    check_out("pf60", m0, a_score1, a_score2, a_serve_side, a_launch, a_launch_dir,
              a_ball_hold, a_point, a_game_over, a_winner);
    check_out("pf1", m1, b_score1, b_score2, b_serve_side, b_launch, b_launch_dir,
              b_ball_hold, b_point, b_game_over, b_winner);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      m0 = mreset();
      m1 = mreset();
    end else begin
      m0 = mstep(m0, 60, p1_srv, p2_srv, miss_l, miss_r, frame_tick);
      m1 = mstep(m1, 1,  p1_srv, p2_srv, miss_l, miss_r, frame_tick);
    end
    @(negedge clk);
    check_both();
  endtask

  task automatic ticks(input int n);
    frame_tick = 1'b1;
    repeat (n) step();
    frame_tick = 1'b0;
  endtask

  task automatic serve_now();
    if (m0.side[1]) p1_srv = 1'b1;
    else p2_srv = 1'b1;
    step();
    p1_srv = 1'b0; p2_srv = 1'b0;
    step();
  endtask

  initial begin
    int iter;
    rst_n = 1'b0; frame_tick = 1'b0; miss_l = 1'b0; miss_r = 1'b0;
    p1_srv = 1'b0; p2_srv = 1'b0;
    m0 = mreset(); m1 = mreset();

    @(negedge clk);
    chk("rst.score1", 32'(a_score1), 0);
    chk("rst.serve_side", 32'(a_serve_side), 32'h1);
    chk("rst.ball_hold", 32'(a_ball_hold), 1);
    chk("rst.launch_dir", 32'(a_launch_dir), 0);
    chk("rst.winner", 32'(a_winner), 0);
    step(); step();
    rst_n = 1'b1;
    step(); step();

    // wrong server first, then the designated server
    p1_srv = 1'b1; step(); p1_srv = 1'b0; step();
    chk("p1_ignored.launch", 32'(a_launch), 0);
    p2_srv = 1'b1; step();
    chk("srv.launch", 32'(a_launch), 1);
    chk("srv.launch_dir", 32'(a_launch_dir), 1);
    chk("srv.ball_hold", 32'(a_ball_hold), 0);
    chk("srv.serve_side", 32'(a_serve_side), 0);
    p2_srv = 1'b0; step();
    chk("srv.launch_pulse", 32'(a_launch), 0);

    // P1 point, then a back-to-back tick stream through the hold
    miss_r = 1'b1; step();
    chk("pt.score1", 32'(a_score1), 1);
    chk("pt.point", 32'(a_point), 1);
    miss_r = 1'b0; frame_tick = 1'b1; step();
    chk("pt.point_pulse", 32'(a_point), 0);
    chk("pf1.first_tick_exit", 32'(b_serve_side), 32'h1);
    ticks(58);
    chk("hold.tick59_side", 32'(a_serve_side), 0);
    chk("hold.tick59_hold", 32'(a_ball_hold), 1);
    ticks(1);
    chk("hold.tick60_side", 32'(a_serve_side), 32'h1);

    // simultaneous misses, then long-held miss levels
    serve_now();
    miss_l = 1'b1; miss_r = 1'b1; step();
    chk("both.score2", 32'(a_score2), 1);
    chk("both.score1", 32'(a_score1), 1);
    repeat (999) step();
    miss_l = 1'b0; miss_r = 1'b0; step();
    chk("held.score2", 32'(a_score2), 1);
    ticks(60); step();
    chk("both.serve_side", 32'(a_serve_side), 32'h2);

    // P1 runs out the match
    iter = 0;
    while (!m0.go && iter < 20) begin
      serve_now();
      miss_r = 1'b1; step(); miss_r = 1'b0; step();
      ticks(60); step();
      iter++;
    end
    if (!m0.go) chk("win_loop_bound", 0, 1);
    chk("over.game_over", 32'(a_game_over), 1);
    chk("over.winner", 32'(a_winner), 32'h2);
    chk("over.score1", 32'(a_score1), 9);
    miss_r = 1'b1; step(); miss_r = 1'b0; step();
    chk("over.miss_ignored", 32'(a_score1), 9);
    p2_srv = 1'b1; step();
    chk("restart.score1", 32'(a_score1), 0);
    chk("restart.score2", 32'(a_score2), 0);
    chk("restart.serve_side", 32'(a_serve_side), 32'h1);
    chk("restart.launch", 32'(a_launch), 0);
    chk("restart.game_over", 32'(a_game_over), 0);
    p2_srv = 1'b0; step();

    // reset mid point-hold with the server's button held through release
    serve_now();
    miss_r = 1'b1; step(); miss_r = 1'b0; step();
    ticks(30);
    p2_srv = 1'b1; rst_n = 1'b0;
    m0 = mreset(); m1 = mreset();
    #1;
    check_both();
    chk("midrst.score1", 32'(a_score1), 0);
    step();
    rst_n = 1'b1;
    repeat (3) begin
      step();
      chk("midrst.no_launch", 32'(a_ball_hold), 1);
    end
    p2_srv = 1'b0; step();
    p2_srv = 1'b1; step();
    chk("midrst.repress_launch", 32'(a_launch), 1);
    p2_srv = 1'b0; step();

    // random play
    repeat (6000) begin
      p1_srv     = ($urandom_range(0, 7) == 0);
      p2_srv     = ($urandom_range(0, 7) == 0);
      miss_l     = ($urandom_range(0, 15) == 0);
      miss_r     = ($urandom_range(0, 15) == 0);
      frame_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1499) == 0) begin
        rst_n = 1'b0;
        m0 = mreset(); m1 = mreset();
        step();
        rst_n = 1'b1;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
